// File: rtl/axis_line_packetizer_pkg.sv
// Shared definitions for the line packetizer: state encoding, header layout
// and the header field bundle handed to the serializer.
package axis_line_packetizer_pkg;

  localparam int         HDR_LEN       = 6;
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HDR_WAIT = 2'd1,
    ST_HDR      = 2'd2,
    ST_PAY      = 2'd3
  } state_e;

  typedef logic [2:0] hdr_idx_t;

  // Header byte order (big-endian), shared with the host-side depacketizer.
  localparam hdr_idx_t HDR_IDX_MAGIC    = 3'd0;
  localparam hdr_idx_t HDR_IDX_FRAME_HI = 3'd1;
  localparam hdr_idx_t HDR_IDX_FRAME_LO = 3'd2;
  localparam hdr_idx_t HDR_IDX_LINE_HI  = 3'd3;
  localparam hdr_idx_t HDR_IDX_LINE_LO  = 3'd4;
  localparam hdr_idx_t HDR_IDX_FRAG     = 3'd5;
  localparam hdr_idx_t HDR_IDX_LAST     = 3'(HDR_LEN - 1);

  typedef struct packed {
    logic [15:0] frame_id;
    logic [15:0] line_id;
    logic [7:0]  frag;
  } hdr_fields_t;

endpackage

// File: rtl/axis_line_packetizer_if.sv
// 8-bit AXI-Stream bundle used on both sides of the packetizer.
// tuser marks end of frame on the pixel side; unused (driven 0) on the packet side.
interface axis_line_packetizer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_line_packetizer_pkt_hdr_serializer.sv
// Snapshots the frame/line/fragment counters when a header starts and
// presents header[hdr_idx] so the counters can move on during the packet.
module pkt_hdr_serializer
  import axis_line_packetizer_pkg::*;
#(
  parameter logic [7:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  hdr_fields_t fields_i,
  input  hdr_idx_t    hdr_idx,
  output logic [7:0]  hdr_byte
);

  hdr_fields_t fields_q, fields_d;

  // Capture the counters on HDR entry, hold them for the whole header.
  always_comb begin
    fields_d = fields_q;
    if (load) fields_d = fields_i;
  end

  // Snapshot register.
  always_ff @(posedge clk) begin
    if (rst) fields_q <= '0;
    else     fields_q <= fields_d;
  end

  // Header byte mux, big-endian counters.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      HDR_IDX_MAGIC:    hdr_byte = MAGIC;
      HDR_IDX_FRAME_HI: hdr_byte = fields_q.frame_id[15:8];
      HDR_IDX_FRAME_LO: hdr_byte = fields_q.frame_id[7:0];
      HDR_IDX_LINE_HI:  hdr_byte = fields_q.line_id[15:8];
      HDR_IDX_LINE_LO:  hdr_byte = fields_q.line_id[7:0];
      HDR_IDX_FRAG:     hdr_byte = fields_q.frag;
      default:          hdr_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/axis_line_packetizer.sv
// Pixel stream to UDP-payload packetizer: 6-byte header followed by up to
// MAX_PAYLOAD pixel bytes; long lines are split into numbered fragments.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | not capturing; beats dropped while enabled until a tuser beat
// HDR_WAIT | between packets; waits for pixel data before starting a header
// HDR      | sending the 6 header bytes
// PAY      | combinational pass-through of pixel bytes until packet end
module axis_line_packetizer
  import axis_line_packetizer_pkg::*;
#(
  parameter int         MAX_PAYLOAD  = 1024,
  parameter int         IMAGE_HEIGHT = 600,
  parameter logic [7:0] MAGIC        = MAGIC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic busy,
  output logic overrun,
  axis_line_packetizer_if.slave  s_axis,
  axis_line_packetizer_if.master m_axis
);

  localparam int              CW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_PAYLOAD - 1);
  localparam logic [15:0]     HEIGHT_W = 16'(IMAGE_HEIGHT);

  state_e          state_q, state_d;
  logic [15:0]     frame_id_q, frame_id_d;
  logic [15:0]     line_id_q, line_id_d;
  logic [7:0]      frag_q, frag_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  hdr_idx_t        hdr_idx_q, hdr_idx_d;
  logic            overrun_q, overrun_d;

  logic            load_hdr;
  logic            pay_last;
  logic [15:0]     line_inc;
  logic [7:0]      hdr_byte;
  hdr_fields_t     cur_fields;

  // A size split on the same byte as tlast/tuser is still just one packet end.
  assign pay_last   = s_axis.tlast | s_axis.tuser | (byte_cnt_q == CNT_LAST);
  assign line_inc   = line_id_q + 16'd1;
  assign cur_fields = {frame_id_q, line_id_q, frag_q};

  pkt_hdr_serializer #(.MAGIC(MAGIC)) u_hdr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_hdr),
    .fields_i (cur_fields),
    .hdr_idx  (hdr_idx_q),
    .hdr_byte (hdr_byte)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      frame_id_q <= '0;
      line_id_q  <= '0;
      frag_q     <= '0;
      byte_cnt_q <= '0;
      hdr_idx_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_id_q <= frame_id_d;
      line_id_q  <= line_id_d;
      frag_q     <= frag_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_idx_q  <= hdr_idx_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next state and counter updates; packet-end rules take tuser first.
  always_comb begin
    state_d    = state_q;
    frame_id_d = frame_id_q;
    line_id_d  = line_id_q;
    frag_d     = frag_q;
    byte_cnt_d = byte_cnt_q;
    hdr_idx_d  = hdr_idx_q;
    overrun_d  = overrun_q;
    load_hdr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && s_axis.tvalid && s_axis.tuser) begin
          state_d   = ST_HDR_WAIT;
          line_id_d = '0;
          frag_d    = '0;
        end
      end
      ST_HDR_WAIT: begin
        if (s_axis.tvalid) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
          load_hdr  = 1'b1;
        end
      end
      ST_HDR: begin
        if (m_axis.tready) begin
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == HDR_IDX_LAST) begin
            state_d    = ST_PAY;
            byte_cnt_d = '0;
          end
        end
      end
      ST_PAY: begin
        if (s_axis.tvalid && m_axis.tready) begin
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (pay_last) begin
            if (s_axis.tuser) begin
              frame_id_d = frame_id_q + 16'd1;
              line_id_d  = '0;
              frag_d     = '0;
              state_d    = enable ? ST_HDR_WAIT : ST_IDLE;
            end else if (s_axis.tlast) begin
              frag_d  = '0;
              state_d = ST_HDR_WAIT;
              if (line_inc == HEIGHT_W) begin
                overrun_d  = 1'b1;
                frame_id_d = frame_id_q + 16'd1;
                line_id_d  = '0;
              end else begin
                line_id_d = line_inc;
              end
            end else begin
              frag_d  = frag_q + 8'd1;
              state_d = ST_HDR_WAIT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and data muxing per state.
  always_comb begin
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tdata  = 8'h00;
    m_axis.tlast  = 1'b0;
    m_axis.tuser  = 1'b0;
    case (state_q)
      ST_IDLE: s_axis.tready = enable;
      ST_HDR: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = hdr_byte;
      end
      ST_PAY: begin
        s_axis.tready = m_axis.tready;
        m_axis.tvalid = s_axis.tvalid;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tlast  = pay_last;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_axis_line_packetizer.sv
module tb_axis_line_packetizer;

  localparam int MAXP   = 4;
  localparam int HEIGHT = 4;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
  logic overrun;

  axis_line_packetizer_if s_if ();
  axis_line_packetizer_if m_if ();

  axis_line_packetizer #(
    .MAX_PAYLOAD  (MAXP),
    .IMAGE_HEIGHT (HEIGHT),
    .MAGIC        (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .busy    (busy),
    .overrun (overrun),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] line_buf[$];
  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  bit         rnd_ready = 1'b0;
  int         stray_last = 0;
  int         m_frame = 0;
  int         m_line = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always ready, or a coin flip per cycle.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer, checks stall stability.
  initial begin
    bit         stall_pend = 1'b0;
    logic [7:0] stall_d = 8'h00;
    logic       stall_l = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (stall_pend) begin
          check("stall_tvalid", 32'(m_if.tvalid), 32'd1);
          check("stall_tdata", 32'(m_if.tdata), 32'(stall_d));
          check("stall_tlast", 32'(m_if.tlast), 32'(stall_l));
        end
        if (m_if.tvalid && m_if.tready) begin
          stall_pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h with nothing expected", m_if.tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_tdata", 32'(m_if.tdata), 32'(e.d));
            check("out_tlast", 32'(m_if.tlast), 32'(e.l));
          end
        end else if (m_if.tvalid) begin
          stall_pend = 1'b1;
          stall_d    = m_if.tdata;
          stall_l    = m_if.tlast;
        end else begin
          stall_pend = 1'b0;
        end
      end else begin
        stall_pend = 1'b0;
        if (m_if.tvalid && m_if.tready && m_if.tlast) stray_last++;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    int n = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_if.tready && n < 2000);
    if (!s_if.tready) begin
      errors++;
      $display("FAIL handshake_timeout: got no tready after %0d cycles, required tready=1", n);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  // Two junk beats then a tuser beat, all dropped while IDLE.
  task automatic start_frame();
    send_beat(8'($urandom), 1'b0, 1'b0);
    send_beat(8'($urandom), 1'b1, 1'b0);
    send_beat(8'($urandom), 1'b1, 1'b1);
    m_line = 0;
  endtask

  // Reference model: a line becomes ceil(n/MAXP) packets; then drive its beats.
  task automatic send_line(input bit eof, input bit tl);
    int n  = line_buf.size();
    int nf = (n + MAXP - 1) / MAXP;
    for (int k = 0; k < nf; k++) begin
      int lo = k * MAXP;
      int hi = (lo + MAXP < n) ? lo + MAXP : n;
      exp_q.push_back('{8'hA5, 1'b0});
      exp_q.push_back('{8'(m_frame >> 8), 1'b0});
      exp_q.push_back('{8'(m_frame), 1'b0});
      exp_q.push_back('{8'(m_line >> 8), 1'b0});
      exp_q.push_back('{8'(m_line), 1'b0});
      exp_q.push_back('{8'(k % 256), 1'b0});
      for (int j = lo; j < hi; j++) exp_q.push_back('{line_buf[j], j == hi - 1});
    end
    if (eof) begin
      m_frame = (m_frame + 1) % 65536;
      m_line  = 0;
    end else begin
      m_line++;
      if (m_line == HEIGHT) begin
        m_line  = 0;
        m_frame = (m_frame + 1) % 65536;
      end
    end
    for (int i = 0; i < n; i++)
      send_beat(line_buf[i], (i == n - 1) && (tl || !eof), (i == n - 1) && eof);
  endtask

  task automatic rand_line(input int len);
    line_buf.delete();
    for (int i = 0; i < len; i++) line_buf.push_back(8'($urandom));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    enable      = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_m_tuser", 32'(m_if.tuser), 32'd0);
    check("idle_tready_dis", 32'(s_if.tready), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("idle_tready_en", 32'(s_if.tready), 32'd1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Junk then A0..A3.
    start_frame();
    line_buf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_line(1'b0, 1'b1);
    wait_drain();
    check("busy_in_frame", 32'(busy), 32'd1);

    // 10-byte line split into 4/4/2; then an exact 4-byte line, then end of frame.
    rand_line(10);
    send_line(1'b0, 1'b1);
    rand_line(4);
    send_line(1'b0, 1'b1);
    rand_line(3);
    send_line(1'b1, 1'b1);
    wait_drain();

    // Random backpressure over random frames.
    rnd_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int nl = (f < 2) ? 3 : int'($urandom_range(1, 3));
      for (int l = 0; l < nl; l++) begin
        rand_line(int'($urandom_range(1, 10)));
        send_line(l == nl - 1, 1'($urandom_range(0, 1)));
      end
    end
    wait_drain();

    // Overrun: HEIGHT lines without tuser.
    for (int l = 0; l < HEIGHT - 1; l++) begin
      rand_line(int'($urandom_range(1, 6)));
      send_line(1'b0, 1'b1);
    end
    wait_drain();
    check("overrun_before", 32'(overrun), 32'd0);
    rand_line(3);
    send_line(1'b0, 1'b1);
    wait_drain();
    check("overrun_after", 32'(overrun), 32'd1);
    rand_line(5);
    send_line(1'b0, 1'b1);

    // Drop enable mid-frame: frame still completes, then IDLE.
    enable = 1'b0;
    rand_line(6);
    send_line(1'b1, 1'b1);
    wait_drain();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tready_off", 32'(s_if.tready), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a header.
    enable = 1'b1;
    start_frame();
    chk_en = 1'b0;
    s_if.tdata  = 8'h5A;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tvalid = 1'b1;
    begin
      int n = 0;
      while (!m_if.tvalid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("hdr_started", 32'(m_if.tvalid), 32'd1);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_tlast", 32'(stray_last), 32'd0);
    exp_q.delete();
    m_frame = 0;
    m_line  = 0;
    chk_en  = 1'b1;
    start_frame();
    rand_line(7);
    send_line(1'b1, 1'b1);
    wait_drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
